pe_port_arbiter: RTL and testbench
==================================

# pe_port_arbiter

Two-requester arbiter for the router's PE injection port in one mesh tile. It shares the single PE-to-router channel between requester A (host/PCI ingress traffic) and requester B (locally generated PE result packets). Each requester has a 2-deep input FIFO. Grants are round-robin with bounded bursts, and the output is registered and drives the router's PE valid/data inputs directly.

## Interface
- x_coord, default 'd0: tile X coordinate; carried for tile identification only, no effect on arbitration.
- y_coord, default 'd0: tile Y coordinate; carried for tile identification only, no effect on arbitration.
- BURST_MAX, default 4: maximum consecutive grants to one requester while the other is pending; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-low.
- i_valid_a  in  1  requester A word valid.
- i_data_a  in  `total_width  requester A packet word.
- o_ready_a  out  1  requester A may push.
- i_valid_b  in  1  requester B word valid.
- i_data_b  in  `total_width  requester B packet word.
- o_ready_b  out  1  requester B may push.
- o_valid  out  1  word valid toward router PE input.
- o_data  out  `total_width  word toward router PE input.
- i_ready  in  1  router PE port ready.
- o_grant  out  2  one-hot source of the current o_data: bit0 = A, bit1 = B; 0 when o_valid = 0.

## Operation
- FIFO push: a word is pushed into FIFO x when i_valid_x & o_ready_x.
- o_ready_x = rst & (cnt_x != 2). It is derived from the registered count, with no path from i_ready.
- Output register load condition: (!o_valid | i_ready) & (fifo_a nonempty | fifo_b nonempty).
  - On load, the head of the selected FIFO is popped into o_data / o_grant.
  - If the condition holds with both FIFOs empty, o_valid drops to 0.
- Simultaneous push and pop on one FIFO: count unchanged; the head advances correctly, including at count 1.
- FSM states: IDLE, SERVE_A, SERVE_B. A burst counter bcnt tracks grants to the current requester.
  - Transitions are evaluated only on load cycles; otherwise the state holds.
- From IDLE:
  - Only one FIFO nonempty: serve it, bcnt = 1.
  - Both nonempty: serve the requester opposite to the last pointer, bcnt = 1.
- In SERVE_x:
  - Other requester pending and (fifo_x empty or bcnt == BURST_MAX): switch to SERVE_other, bcnt = 1.
  - fifo_x nonempty and bcnt < BURST_MAX: stay, bcnt + 1.
  - fifo_x nonempty and other empty: stay, bcnt saturates at BURST_MAX.
  - Both empty: go to IDLE.
- Last pointer: updated to the granted requester on every load.
- bcnt width: 4 bits; saturating, never wraps.

## Timing
- Reset values: o_valid = 0, o_data = 0, o_grant = 2'b00, o_ready_a = o_ready_b = 0 while rst = 0. Internally: FIFOs empty, FSM in IDLE, last pointer = B (A wins first tie), bcnt = 0.
- Reset mid-operation: both FIFOs are flushed and the output word is discarded even if i_ready = 0; no partial state survives.
- Latency: a word pushed at edge N appears on o_valid/o_data after edge N+1, if the output is free.
- Throughput: one word per cycle aggregate while i_ready = 1; each requester can sustain one per cycle when alone.
- Stall: while o_valid & !i_ready, o_data and o_grant hold stable and no FIFO pops.
- Full boundary: at cnt_x = 2, o_ready_x = 0 in the same cycle the count reaches 2; a push offered then is not taken.
- Empty boundary: a word pushed into an empty FIFO is not forwarded in the same cycle (no bypass).

## Configuration
- PE_ARB_FIXED_PRIO_EN defined: requester A always wins when both FIFOs are nonempty. The FSM and bcnt stay in the default state; BURST_MAX is ignored.
- PE_ARB_FIXED_PRIO_EN undefined: round-robin with BURST_MAX bursting as described in Operation.

## Test plan
- Reset: hold rst = 0 for 3 cycles with both valids high -> o_ready_a/b = 0, o_valid = 0, o_grant = 0. First edge after release: ready = 1.
- Single source: push A words 0x11..0x15 on consecutive cycles with i_ready = 1 -> same order on o_data, first one edge after its push, o_grant = 01 throughout, no gaps.
- Contention, BURST_MAX = 4: both sources continuously valid, i_ready = 1 -> grant pattern A×4, B×4, A×4 ...; no word lost or duplicated.
- Backpressure: i_ready = 0 for 10 cycles with both sources pushing -> o_data stable, each FIFO holds 2 words, o_ready_a/b = 0. After release, all 5 words drain in push order per source.
- Mid-operation reset: rst = 0 for one cycle with both FIFOs full and o_valid = 1 -> the next cycle shows o_valid = 0 and empty FIFOs; the first tie after reset grants A.
- PE_ARB_FIXED_PRIO_EN build: both sources continuously valid -> only A granted while A supplies every cycle; B is granted only in cycles where fifo_a is empty.

Source files
------------

// File: rtl/pe_port_arbiter.sv
// rtl/pe_port_arbiter.sv - two-requester PE injection port arbiter, 2-deep FIFOs, round-robin bursts
// PE_ARB_FIXED_PRIO_EN: requester A always wins ties; FSM and burst counter stay idle.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 32
`endif

module pe_port_arbiter #(
  parameter logic [7:0]  x_coord   = 'd0,
  parameter logic [7:0]  y_coord   = 'd0,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid_a,
  input  logic [`TOTAL_WIDTH-1:0] i_data_a,
  output logic                    o_ready_a,
  input  logic                    i_valid_b,
  input  logic [`TOTAL_WIDTH-1:0] i_data_b,
  output logic                    o_ready_b,
  output logic                    o_valid,
  output logic [`TOTAL_WIDTH-1:0] o_data,
  input  logic                    i_ready,
  output logic [1:0]              o_grant
);

  localparam int W = `TOTAL_WIDTH;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;

  // Coordinates only identify the tile; they never steer arbitration.
  logic unused_cfg;
  assign unused_cfg = ^{x_coord, y_coord, 4'(BURST_MAX)};

  logic [W-1:0] mem_a [2];
  logic [W-1:0] mem_b [2];
  logic         wp_a, rp_a, wp_b, rp_b;
  logic [1:0]   cnt_a, cnt_b;
  logic         ne_a, ne_b, push_a, push_b, pop_a, pop_b;

  logic [1:0]   state, state_n;
  logic [3:0]   bcnt, bcnt_n;
  logic         last_b;
  logic         free, load, sel_b;

  assign o_ready_a = rst & (cnt_a != 2'd2);
  assign o_ready_b = rst & (cnt_b != 2'd2);
  assign ne_a      = (cnt_a != 2'd0);
  assign ne_b      = (cnt_b != 2'd0);
  assign push_a    = i_valid_a & o_ready_a;
  assign push_b    = i_valid_b & o_ready_b;
  assign pop_a     = load & ~sel_b;
  assign pop_b     = load & sel_b;

  always_ff @(posedge clk) begin
    if (push_a) mem_a[wp_a] <= i_data_a;
    if (push_b) mem_b[wp_b] <= i_data_b;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_a  <= 1'b0;
      rp_a  <= 1'b0;
      cnt_a <= 2'd0;
      wp_b  <= 1'b0;
      rp_b  <= 1'b0;
      cnt_b <= 2'd0;
    end else begin
      if (push_a) wp_a <= ~wp_a;
      if (pop_a)  rp_a <= ~rp_a;
      if (push_b) wp_b <= ~wp_b;
      if (pop_b)  rp_b <= ~rp_b;
      case ({push_a, pop_a})
        2'b10:   cnt_a <= cnt_a + 2'd1;
        2'b01:   cnt_a <= cnt_a - 2'd1;
        default: cnt_a <= cnt_a;
      endcase
      case ({push_b, pop_b})
        2'b10:   cnt_b <= cnt_b + 2'd1;
        2'b01:   cnt_b <= cnt_b - 2'd1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

  always_comb begin
    free    = ~o_valid | i_ready;
    load    = free & (ne_a | ne_b);
    sel_b   = 1'b0;
    state_n = state;
    bcnt_n  = bcnt;
`ifdef PE_ARB_FIXED_PRIO_EN
    sel_b = ~ne_a;
`else
    case (state)
      SERVE_A: sel_b = ne_b & (~ne_a | (bcnt == 4'(BURST_MAX)));
      SERVE_B: sel_b = ~(ne_a & (~ne_b | (bcnt == 4'(BURST_MAX))));
      default: sel_b = (ne_a & ne_b) ? ~last_b : ne_b;
    endcase
    if (load) begin
      state_n = sel_b ? SERVE_B : SERVE_A;
      // Burst continues only when the same requester keeps the channel.
      if (state == state_n)
        bcnt_n = (bcnt == 4'(BURST_MAX)) ? bcnt : bcnt + 4'd1;
      else
        bcnt_n = 4'd1;
    end else if (free) begin
      state_n = IDLE;
      bcnt_n  = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_grant <= 2'b00;
      state   <= IDLE;
      bcnt    <= 4'd0;
      last_b  <= 1'b1;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= sel_b ? mem_b[rp_b] : mem_a[rp_a];
      o_grant <= sel_b ? 2'b10 : 2'b01;
      last_b  <= sel_b;
      state   <= state_n;
      bcnt    <= bcnt_n;
    end else if (free) begin
      o_valid <= 1'b0;
      o_grant <= 2'b00;
      state   <= state_n;
      bcnt    <= bcnt_n;
    end
  end

endmodule

// File: tb/tb_pe_port_arbiter.sv
// tb/tb_pe_port_arbiter.sv - scoreboard bench for pe_port_arbiter against a queue-based reference model
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 32
`endif

module tb_pe_port_arbiter;
  localparam int W  = `TOTAL_WIDTH;
  localparam int BM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid_a, i_valid_b, i_ready;
  logic [W-1:0] i_data_a, i_data_b;
  logic         o_ready_a, o_ready_b, o_valid;
  logic [W-1:0] o_data;
  logic [1:0]   o_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_port_arbiter #(.x_coord(8'd0), .y_coord(8'd0), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .i_valid_a(i_valid_a), .i_data_a(i_data_a), .o_ready_a(o_ready_a),
    .i_valid_b(i_valid_b), .i_data_b(i_data_b), .o_ready_b(o_ready_b),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_grant(o_grant)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-source word queues, output slot, and the arbitration rules
  logic [W-1:0] qa[$], qb[$];
  logic [W-1:0] exp_d[$];
  logic [1:0]   exp_g[$];
  bit           m_valid;
  bit           m_was_reset;
  int           owner, m_bcnt, last;

  always @(posedge clk) begin
    if (!rst) begin
      qa.delete(); qb.delete(); exp_d.delete(); exp_g.delete();
      m_valid = 0; owner = 0; m_bcnt = 0; last = 2; m_was_reset = 1;
    end else begin
      bit ra, rb, na, nb, fr;
      int src;
      m_was_reset = 0;
      ra = qa.size() < 2;
      rb = qb.size() < 2;
      na = qa.size() > 0;
      nb = qb.size() > 0;
      fr = !m_valid || i_ready;
      if (fr && (na || nb)) begin
`ifdef PE_ARB_FIXED_PRIO_EN
        src = na ? 1 : 2;
`else
        if (owner == 0) begin
          src = (na && nb) ? ((last == 1) ? 2 : 1) : (na ? 1 : 2);
          m_bcnt = 1;
        end else begin
          bit cur_ne, oth_ne;
          cur_ne = (owner == 1) ? na : nb;
          oth_ne = (owner == 1) ? nb : na;
          if (oth_ne && (!cur_ne || m_bcnt == BM)) begin
            src = 3 - owner;
            m_bcnt = 1;
          end else begin
            src = owner;
            if (m_bcnt < BM) m_bcnt++;
          end
        end
        owner = src;
`endif
        last = src;
        if (src == 1) begin
          exp_d.push_back(qa.pop_front());
          exp_g.push_back(2'b01);
        end else begin
          exp_d.push_back(qb.pop_front());
          exp_g.push_back(2'b10);
        end
        m_valid = 1;
      end else if (fr) begin
        m_valid = 0;
        owner = 0;
        m_bcnt = 0;
      end
      if (i_valid_a && ra) qa.push_back(i_data_a);
      if (i_valid_b && rb) qb.push_back(i_data_b);
    end
  end

  // Monitor: compares presented output against the scoreboard front, pops on handshake
  always @(negedge clk) begin
    chk("ready_a", o_ready_a, rst && qa.size() < 2);
    chk("ready_b", o_ready_b, rst && qb.size() < 2);
    chk("o_valid", o_valid, exp_d.size() > 0);
    if (m_was_reset) chk("reset_o_data", o_data, 0);
    if (!o_valid) begin
      chk("idle_grant", o_grant, 2'b00);
    end else if (exp_d.size() > 0) begin
      chk("o_data", o_data, exp_d[0]);
      chk("o_grant", o_grant, exp_g[0]);
      if (i_ready && rst) begin
        void'(exp_d.pop_front());
        void'(exp_g.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_data_a = $urandom;
      i_data_b = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0; i_valid_a = 1'b1; i_valid_b = 1'b1; i_ready = 1'b1;
    i_data_a = '0; i_data_b = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1; i_valid_a = 1'b0; i_valid_b = 1'b0;
    step(3);

    for (int k = 0; k < 5; k++) begin
      i_valid_a = 1'b1;
      i_data_a = W'(32'h11 + k);
      @(posedge clk);
      #1;
    end
    i_valid_a = 1'b0;
    step(5);

    i_valid_a = 1'b1; i_valid_b = 1'b1;
    step(40);
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    step(5);

    i_ready = 1'b0; i_valid_a = 1'b1; i_valid_b = 1'b1;
    step(10);
    chk("bp_full_a", o_ready_a, 1'b0);
    chk("bp_full_b", o_ready_b, 1'b0);
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_ready = 1'b1;
    step(10);

    i_ready = 1'b0; i_valid_a = 1'b1; i_valid_b = 1'b1;
    step(4);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_ready = 1'b1;
    step(1);
    chk("tie_after_reset", o_grant, 2'b01);
    step(5);

    for (int c = 0; c < 3000; c++) begin
      i_valid_a = ($urandom_range(0, 3) != 0);
      i_valid_b = ($urandom_range(0, 3) != 0);
      i_ready   = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rst = 1'b1; i_valid_a = 1'b0; i_valid_b = 1'b0; i_ready = 1'b1;
    step(10);
    chk("drain_empty", exp_d.size(), 0);
    chk("fifo_a_empty", qa.size(), 0);
    chk("fifo_b_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
